// File: rtl/display_scan_ctrl.sv
// Time-multiplexed digit scan controller: digit select, one-hot anodes with a
// blanking gap at each digit change, and frame-aligned latch strobes.
module display_scan_ctrl #(
  parameter int DIGITS   = 5,
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              update_req,
  output logic [2:0]        sel,
  output logic [DIGITS-1:0] anode,
  output logic              blank,
  output logic              frame,
  output logic              latch
);

  localparam int TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = $clog2(DIGITS);

  typedef enum logic [1:0] {IDLE, BLANKING, ON} state_t;

  state_t          state_p0, state_nxt;
  logic [TW-1:0]   tick_p0, tick_nxt;
  logic [IW-1:0]   idx_p0, idx_nxt;
  logic            pending_p0;
  logic            frame_start;

  // Stage p0: scan state; tick runs 0..PRESCALE-1 across a whole slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      tick_p0  <= '0;
      idx_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      tick_p0  <= tick_nxt;
      idx_p0   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state_p0;
    tick_nxt  = tick_p0;
    idx_nxt   = idx_p0;
    if (!en) begin
      state_nxt = IDLE;
      tick_nxt  = '0;
      idx_nxt   = '0;
    end else begin
      case (state_p0)
        IDLE: begin
          state_nxt = BLANKING;
          tick_nxt  = '0;
          idx_nxt   = '0;
        end
        BLANKING: begin
          tick_nxt = tick_p0 + 1'b1;
          if (tick_p0 == TW'(BLANK - 1)) state_nxt = ON;
        end
        ON: begin
          if (tick_p0 == TW'(PRESCALE - 1)) begin
            state_nxt = BLANKING;
            tick_nxt  = '0;
            idx_nxt   = (idx_p0 == IW'(DIGITS - 1)) ? '0 : idx_p0 + 1'b1;
          end else begin
            tick_nxt = tick_p0 + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          tick_nxt  = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  assign frame_start = (state_p0 == BLANKING) && (idx_p0 == '0) && (tick_p0 == '0);

  // Stage p1: registered outputs decoded from p0; pending survives IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel        <= '0;
      anode      <= '0;
      blank      <= 1'b1;
      frame      <= 1'b0;
      latch      <= 1'b0;
      pending_p0 <= 1'b0;
    end else begin
      sel   <= 3'(idx_p0);
      anode <= (state_p0 == ON) ? (DIGITS'(1) << idx_p0) : '0;
      blank <= (state_p0 != ON);
      frame <= frame_start;
      latch <= frame_start && (pending_p0 || update_req);
      if (frame_start)     pending_p0 <= 1'b0;
      else if (update_req) pending_p0 <= 1'b1;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with DIGITS=5, PRESCALE=8, BLANK=2.
module tb_display_scan_ctrl;
  localparam int D = 5;
  localparam int P = 8;
  localparam int B = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0;
  logic         update_req = 1'b0;
  logic [2:0]   sel;
  logic [D-1:0] anode;
  logic         blank, frame, latch;

  int n_cmp = 0;
  int n_bad = 0;

  logic [10:0] exp_q[$];
  bit          m_act, m_pend;
  int          m_n;

  always #5 clk = ~clk;

  display_scan_ctrl #(.DIGITS(D), .PRESCALE(P), .BLANK(B)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .update_req(update_req),
    .sel(sel), .anode(anode), .blank(blank), .frame(frame), .latch(latch)
  );

  // Output word {sel, anode, blank, frame, latch} for one cycle, from the
  // frame position n counted from the first blanked cycle of digit 0.
  function automatic logic [10:0] model_out(bit act, int n, bit pend, logic ur);
    int pos, dig;
    bit fs, bl;
    pos = n % P;
    dig = n / P;
    fs  = act && (n == 0);
    bl  = (pos < B);
    if (!act) return {3'd0, 5'd0, 1'b1, 1'b0, 1'b0};
    return {3'(dig), bl ? 5'd0 : 5'(5'd1 << dig), bl, fs, fs && (pend || ur)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act  <= 1'b0;
      m_pend <= 1'b0;
      m_n    <= 0;
      exp_q.delete();
    end else begin
      exp_q.push_back(model_out(m_act, m_n, m_pend, update_req));
      if (m_act && m_n == 0) m_pend <= 1'b0;
      else if (update_req)   m_pend <= 1'b1;
      if (!en) begin
        m_act <= 1'b0;
        m_n   <= 0;
      end else if (!m_act) begin
        m_act <= 1'b1;
        m_n   <= 0;
      end else begin
        m_n <= (m_n + 1) % (D * P);
      end
    end
  end

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sel, anode, blank, frame, latch} !== {3'd0, 5'd0, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_async: got %b required %b", {sel, anode, blank, frame, latch}, 11'b000_00000_100);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_enable();
    logic [10:0] e;
    @(posedge clk); #1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_cmp++;
    if ({sel, anode, blank, frame, latch} !== e) begin
      n_bad++;
      $display("FAIL enable_idle: got %b required %b", {sel, anode, blank, frame, latch}, e);
    end
    en = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      @(posedge clk); #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_cmp++;
      if ({sel, anode, blank, frame, latch} !== e) begin
        n_bad++;
        $display("FAIL enable_sb cyc %0d: got %b required %b", c, {sel, anode, blank, frame, latch}, e);
      end
      if (c == 1) begin
        n_cmp++;
        if (frame !== 1'b1 || sel !== 3'd0) begin
          n_bad++;
          $display("FAIL enable_frame: got frame=%b sel=%0d required frame=1 sel=0", frame, sel);
        end
      end
      if (c == 2 || c == 1) begin
        n_cmp++;
        if (blank !== 1'b1) begin
          n_bad++;
          $display("FAIL enable_blank cyc %0d: got %b required 1", c, blank);
        end
      end
      if (c >= 3 && c <= 8) begin
        n_cmp++;
        if (anode !== 5'b00001) begin
          n_bad++;
          $display("FAIL enable_anode cyc %0d: got %b required 00001", c, anode);
        end
      end
      if (c == 9) begin
        n_cmp++;
        if (sel !== 3'd1 || blank !== 1'b1) begin
          n_bad++;
          $display("FAIL enable_next: got sel=%0d blank=%b required sel=1 blank=1", sel, blank);
        end
      end
    end
  endtask

  task automatic test_scan_latch();
    logic [10:0] e;
    for (int c = 10; c <= 90; c++) begin
      @(posedge clk); #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_cmp++;
      if ({sel, anode, blank, frame, latch} !== e) begin
        n_bad++;
        $display("FAIL scan_sb cyc %0d: got %b required %b", c, {sel, anode, blank, frame, latch}, e);
      end
      n_cmp++;
      if (sel !== 3'(((c - 1) / P) % D) || frame !== (c == 41 || c == 81) ||
          latch !== (c == 41 || c == 81)) begin
        n_bad++;
        $display("FAIL scan_seq cyc %0d: got sel=%0d frame=%b latch=%b required sel=%0d frame=%b latch=%b",
                 c, sel, frame, latch, ((c - 1) / P) % D, (c == 41 || c == 81), (c == 41 || c == 81));
      end
      n_cmp++;
      if ((!blank && !$onehot(anode)) || (blank && anode != '0)) begin
        n_bad++;
        $display("FAIL scan_onehot cyc %0d: got anode=%b blank=%b required one-hot when lit, zero when blank",
                 c, anode, blank);
      end
      if (c == 12 || c == 20 || c == 80) update_req = 1'b1;
      else                               update_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] e;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_cmp++;
      if ({sel, anode, blank, frame, latch} !== e) begin
        n_bad++;
        $display("FAIL rstmid_sb: got %b required %b", {sel, anode, blank, frame, latch}, e);
      end
      if (sel == 3'd3 && blank == 1'b0) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL rstmid_wait: got no lit digit 3 required one within 60 cycles");
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sel, anode, blank, frame, latch} !== {3'd0, 5'd0, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL rstmid_async: got %b required %b", {sel, anode, blank, frame, latch}, 11'b000_00000_100);
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mid_disable();
    logic [10:0] e;
    bit found;
    found = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_cmp++;
      if ({sel, anode, blank, frame, latch} !== e) begin
        n_bad++;
        $display("FAIL middis_sb: got %b required %b", {sel, anode, blank, frame, latch}, e);
      end
      if (sel == 3'd2 && blank == 1'b0) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL middis_wait: got no lit digit 2 required one within 40 cycles");
    end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_cmp++;
      if ({sel, anode, blank, frame, latch} !== e) begin
        n_bad++;
        $display("FAIL middis_off_sb %0d: got %b required %b", i, {sel, anode, blank, frame, latch}, e);
      end
    end
    n_cmp++;
    if (anode !== 5'd0 || blank !== 1'b1 || sel !== 3'd0) begin
      n_bad++;
      $display("FAIL middis_idle: got sel=%0d anode=%b blank=%b required sel=0 anode=00000 blank=1",
               sel, anode, blank);
    end
    en = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      @(posedge clk); #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_cmp++;
      if ({sel, anode, blank, frame, latch} !== e) begin
        n_bad++;
        $display("FAIL middis_re_sb %0d: got %b required %b", i, {sel, anode, blank, frame, latch}, e);
      end
      n_cmp++;
      if (frame !== (i == 1) || blank !== (i < 3) || anode !== ((i == 3) ? 5'b00001 : 5'b00000) || sel !== 3'd0) begin
        n_bad++;
        $display("FAIL middis_restart %0d: got sel=%0d anode=%b blank=%b frame=%b required sel=0 anode=%b blank=%b frame=%b",
                 i, sel, anode, blank, frame, (i == 3) ? 5'b00001 : 5'b00000, (i < 3), (i == 1));
      end
    end
  endtask

  task automatic test_pending_disable();
    logic [10:0] e;
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_cmp++;
      if ({sel, anode, blank, frame, latch} !== e) begin
        n_bad++;
        $display("FAIL pend_idle_sb %0d: got %b required %b", i, {sel, anode, blank, frame, latch}, e);
      end
      n_cmp++;
      if (latch !== 1'b0) begin
        n_bad++;
        $display("FAIL pend_idle_latch %0d: got %b required 0", i, latch);
      end
      update_req = (i == 2 || i == 3);
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_cmp++;
      if ({sel, anode, blank, frame, latch} !== e) begin
        n_bad++;
        $display("FAIL pend_re_sb %0d: got %b required %b", i, {sel, anode, blank, frame, latch}, e);
      end
      n_cmp++;
      if (frame !== (i == 1) || latch !== (i == 1)) begin
        n_bad++;
        $display("FAIL pend_latch %0d: got frame=%b latch=%b required frame=%b latch=%b",
                 i, frame, latch, (i == 1), (i == 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_scan_latch();
    test_reset_mid();
    test_mid_disable();
    test_pending_disable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
